// File: rtl/mole_round_scheduler.sv
// Whac-a-mole round sequencer: picks a hole, shows the mole for a fixed window,
// judges key presses and drives the score FSM's timeUp / W / enable inputs.
module mole_round_scheduler #(
  parameter int unsigned HOLES      = 4,
  parameter int unsigned UP_CYCLES  = 25000000,
  parameter int unsigned GAP_CYCLES = 12500000,
  parameter int unsigned LIVES      = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic             systemClock,
  input  logic             reset,
  input  logic             start,
  input  logic [HOLES-1:0] keys,
  output logic [HOLES-1:0] mole,
  output logic             timeUp,
  output logic             W,
  output logic             enable,
  output logic [1:0]       lives,
  output logic [7:0]       hitCount,
  output logic             gameOver
);

  localparam int unsigned HoleW     = $clog2(HOLES);
  localparam int unsigned MaxCycles = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles);

  typedef enum logic [2:0] {StIdle, StPick, StUp, StJudge, StGap, StOver} state_e;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [HoleW-1:0]   prev_hole_q, prev_hole_d;
  logic [HOLES-1:0]   keys_q, keys_d;
  logic               hit_q, hit_d;
  logic               foul_q, foul_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [1:0]         lives_q, lives_d;
  logic [7:0]         hit_count_q, hit_count_d;

  logic               lfsr_fb;
  logic [HoleW-1:0]   cand;
  logic [HoleW-1:0]   hole;
  logic [HOLES-1:0]   mole_bit;
  logic [HOLES-1:0]   rise;
  logic               verdict;

  // Datapath helpers: LFSR feedback, hole choice, key edges, current verdict
  always_comb begin
    lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    cand     = HoleW'(lfsr_q % 8'(HOLES));
    hole     = cand;
    // Bump to the next hole so the same hole never shows twice in a row
    if (cand == prev_hole_q) begin
      hole = (cand == HoleW'(HOLES - 1)) ? '0 : cand + HoleW'(1);
    end
    mole_bit = {{(HOLES-1){1'b0}}, 1'b1} << prev_hole_q;
    rise     = keys & ~keys_q;
    verdict  = hit_q & ~foul_q;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge systemClock) begin
    if (reset) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      prev_hole_q <= '0;
      keys_q      <= '0;
      hit_q       <= 1'b0;
      foul_q      <= 1'b0;
      timer_q     <= '0;
      lives_q     <= 2'(LIVES);
      hit_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      prev_hole_q <= prev_hole_d;
      keys_q      <= keys_d;
      hit_q       <= hit_d;
      foul_q      <= foul_d;
      timer_q     <= timer_d;
      lives_q     <= lives_d;
      hit_count_q <= hit_count_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_fb};
    prev_hole_d = prev_hole_q;
    keys_d      = keys;
    hit_d       = hit_q;
    foul_d      = foul_q;
    timer_d     = timer_q;
    lives_d     = lives_q;
    hit_count_d = hit_count_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          lives_d     = 2'(LIVES);
          hit_count_d = 8'd0;
          state_d     = StPick;
        end
      end
      StPick: begin
        prev_hole_d = hole;
        hit_d       = 1'b0;
        foul_d      = 1'b0;
        timer_d     = TimerW'(UP_CYCLES - 1);
        state_d     = StUp;
      end
      StUp: begin
        if (|(rise & mole_bit))  hit_d  = 1'b1;
        if (|(rise & ~mole_bit)) foul_d = 1'b1;
        if (timer_q == '0) state_d = StJudge;
        else               timer_d = timer_q - TimerW'(1);
      end
      StJudge: begin
        timer_d = TimerW'(GAP_CYCLES - 1);
        state_d = StGap;
        if (verdict) begin
          if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
        end else begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) state_d = StOver;
        end
      end
      StGap: begin
        if (timer_q == '0) state_d = StPick;
        else               timer_d = timer_q - TimerW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; mole is shown only during UP
  always_comb begin
    mole     = (state_q == StUp) ? mole_bit : '0;
    timeUp   = (state_q == StJudge);
    W        = (state_q == StJudge) & verdict;
    enable   = (state_q == StPick) | (state_q == StUp) | (state_q == StJudge) |
               (state_q == StGap);
    gameOver = (state_q == StOver);
    lives    = lives_q;
    hitCount = hit_count_q;
  end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: directed scenarios plus randomized windows checked
// against a per-window model of lives, hits and the hit verdict.
module tb_mole_round_scheduler;
  localparam int H   = 4;
  localparam int UP  = 4;
  localparam int GAP = 2;
  localparam int LV  = 2;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [H-1:0] keys;
  logic [H-1:0] mole;
  logic         timeUp, W, enable, gameOver;
  logic [1:0]   lives;
  logic [7:0]   hitCount;

  int n_checks = 0;
  int n_fail   = 0;
  int m_lives, m_hits;
  logic [H-1:0] prev_mole;
  bit ok;

  mole_round_scheduler #(
    .HOLES(H), .UP_CYCLES(UP), .GAP_CYCLES(GAP), .LIVES(LV), .LFSR_SEED(8'hA5)
  ) dut (
    .systemClock(clk), .reset(reset), .start(start), .keys(keys), .mole(mole),
    .timeUp(timeUp), .W(W), .enable(enable), .lives(lives), .hitCount(hitCount),
    .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    m_lives = LV;
    m_hits  = 0;
    chk("restart_enable", enable, 1);
    chk("restart_gameover", gameOver, 0);
    chk("restart_lives", lives, LV);
    chk("restart_hits", hitCount, 0);
    chk("pick_mole_dark", mole, 0);
  endtask

  // One window: wait for the mole, press per plan, check JUDGE and the cycle after.
  task automatic run_window(input int exp_wait, input int press_at, input bit wrong,
                            input bit hold_all, output bit wok);
    logic [H-1:0] m;
    int  waited;
    bit  exp_w;
    wok    = 1'b1;
    waited = 0;
    keys   = hold_all ? '1 : '0;
    while (mole === '0 && waited < 20) begin
      chk("no_timeup_outside_judge", timeUp, 0);
      step();
      waited++;
    end
    chk("pick_latency", waited, exp_wait);
    if (waited >= 20) begin
      wok = 1'b0;
      return;
    end
    m = mole;
    chk("mole_onehot", $countones(m) == 1, 1);
    chk("mole_new_hole", m != prev_mole, 1);
    prev_mole = m;
    exp_w = (press_at >= 1) && (press_at <= UP) && !wrong && !hold_all;
    for (int c = 1; c <= UP; c++) begin
      chk("up_mole_stable", mole, m);
      chk("up_no_timeup", timeUp, 0);
      start = 1'($urandom_range(0, 1));
      if (hold_all)          keys = '1;
      else if (c == press_at) keys = wrong ? (m | {m[H-2:0], m[H-1]}) : m;
      else                   keys = '0;
      step();
    end
    start = 1'b0;
    keys  = '0;
    chk("judge_timeup", timeUp, 1);
    chk("judge_w", W, exp_w);
    chk("judge_mole_dark", mole, 0);
    if (exp_w) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
    else       m_lives = m_lives - 1;
    step();
    chk("lives", lives, m_lives);
    chk("hit_count", hitCount, m_hits);
    chk("timeup_single_cycle", timeUp, 0);
    chk("gameover", gameOver, m_lives == 0);
    chk("enable", enable, m_lives != 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    keys  = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    chk("idle_mole", mole, 0);
    chk("idle_enable", enable, 0);
    chk("idle_timeup", timeUp, 0);
    chk("idle_lives", lives, LV);
    chk("idle_hits", hitCount, 0);
    chk("idle_gameover", gameOver, 0);
    prev_mole = 4'b0001;  // reset hole is 0, so the first window avoids it

    restart();
    run_window(1, 2, 1'b0, 1'b0, ok);        // hit on 2nd UP cycle
    run_window(GAP + 1, 3, 1'b1, 1'b0, ok);  // hit plus wrong key -> miss
    run_window(GAP + 1, UP, 1'b0, 1'b0, ok); // hit on final UP cycle
    run_window(GAP + 1, 0, 1'b0, 1'b1, ok);  // keys held through UP -> miss, over
    repeat (3) step();
    chk("over_held_gameover", gameOver, 1);
    chk("over_held_lives", lives, 0);
    chk("over_held_hits", hitCount, 2);
    chk("over_mole", mole, 0);

    restart();
    run_window(1, 0, 1'b0, 1'b0, ok);
    run_window(GAP + 1, 0, 1'b0, 1'b0, ok);
    chk("two_miss_over", gameOver, 1);

    for (int i = 0; i < 200; i++) begin
      int ew;
      ew = GAP + 1;
      if (m_lives == 0) begin
        restart();
        ew = 1;
      end
      run_window(ew, $urandom_range(0, UP), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, ok);
    end

    // Saturating hit counter over a long winning streak
    if (m_lives == 0) begin
      restart();
      run_window(1, 1, 1'b0, 1'b0, ok);
    end
    for (int i = 0; i < 260; i++) begin
      run_window(GAP + 1, $urandom_range(1, UP), 1'b0, 1'b0, ok);
    end
    chk("hits_saturated", hitCount, 255);

    // Reset in the middle of UP
    begin
      int w;
      w = 0;
      while (mole === '0 && w < 20) begin
        step();
        w++;
      end
      chk("mid_reset_found_up", mole != 0, 1);
      repeat (2) step();
      reset = 1'b1;
      step();
      chk("mid_reset_enable", enable, 0);
      chk("mid_reset_mole", mole, 0);
      chk("mid_reset_timeup", timeUp, 0);
      chk("mid_reset_lives", lives, LV);
      chk("mid_reset_hits", hitCount, 0);
      for (int c = 0; c < UP + 2; c++) begin
        step();
        chk("reset_no_timeup", timeUp, 0);
      end
      reset = 1'b0;
      repeat (3) step();
      chk("post_reset_idle", enable, 0);
      chk("post_reset_gameover", gameOver, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Game-round sequencer for whac-a-go. Picks a pseudo-random hole and shows the mole there for a fixed window, then judges the player's key presses.
- Drives the score FSM's timeUp / W / enable inputs:
  - timeUp: one-cycle pulse at end of each window.
  - W: hit verdict for that window.
  - enable: high only while a game is running.
- Also tracks lives and hit count, and declares game over.

Parameters:
HOLES, 4, number of holes/keys; legal range 2..8
UP_CYCLES, 25000000, systemClock cycles a mole stays up; must be >= 2
GAP_CYCLES, 12500000, cycles between windows with no mole shown; must be >= 1
LIVES, 3, misses allowed per game; range 1..3
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
systemClock  in   1      system clock; all logic on rising edge
reset        in   1      synchronous, active-high; returns block to IDLE
start        in   1      start or restart request; level-sampled, acted on in IDLE/OVER only
keys         in   HOLES  player keys, active-high, already synchronized/debounced
mole         out  HOLES  one-hot hole currently showing a mole; all-zero otherwise
timeUp       out  1      one-cycle pulse in JUDGE; to score FSM
W            out  1      hit verdict, valid while timeUp=1; 0 otherwise
enable       out  1      1 in PICK/UP/JUDGE/GAP; 0 in IDLE/OVER
lives        out  2      remaining lives
hitCount     out  8      hits this game; saturates at 255
gameOver     out  1      1 in OVER state only

Behaviour:
- Reset values: state=IDLE, mole=0, timeUp=0, W=0, enable=0, lives=LIVES, hitCount=0, gameOver=0, lfsr=LFSR_SEED, prevHole=0, keysQ=0, hit=0, foul=0, timer=0.
- Reset asserted mid-game returns to IDLE on the next edge; no timeUp pulse is emitted.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle in every state except during reset. Never reaches 0.
- Key edge: rise = keys & ~keysQ; keysQ <= keys every cycle.
- States:
  - IDLE: outputs inactive. If start=1: lives<=LIVES, hitCount<=0, go to PICK.
  - PICK (1 cycle):
    - cand = lfsr % HOLES. If cand==prevHole, hole = (cand+1) % HOLES; else hole = cand.
    - mole <= one-hot(hole); prevHole <= hole.
    - hit<=0, foul<=0, timer<=UP_CYCLES-1. Go to UP.
  - UP:
    - mole held.
    - If rise has the mole bit set: hit<=1.
    - If rise has any other bit set: foul<=1.
    - Both can happen in the same cycle.
    - A rise in the final UP cycle (timer==0) counts.
    - When timer==0, go to JUDGE; otherwise timer decrements.
  - JUDGE (1 cycle):
    - mole=0, timeUp=1, W = hit & ~foul.
    - If W: hitCount += 1, saturating at 255; go to GAP with timer<=GAP_CYCLES-1.
    - If not W: lives -= 1. If the new lives==0, go to OVER; else go to GAP.
  - GAP: mole=0, timeUp=0. Key presses are ignored. When timer==0, go to PICK; otherwise decrement.
  - OVER:
    - gameOver=1, enable=0, mole=0.
    - lives=0 and hitCount are held for display.
    - start=1 restarts: go to PICK with lives=LIVES, hitCount=0.
- start asserted in PICK/UP/JUDGE/GAP is ignored.
- A key held across PICK is not a new rise in UP; only 0->1 transitions count.
- timeUp is never high on two consecutive cycles. The minimum spacing between pulses is GAP_CYCLES+1+UP_CYCLES cycles.
- Hole selection never repeats the same hole in consecutive windows.

Test Plan (UP_CYCLES=4, GAP_CYCLES=2, LIVES=2, HOLES=4):
- Reset then idle 10 cycles -> mole=0, enable=0, timeUp=0, lives=2, hitCount=0, gameOver=0. Pulse start -> enable=1 next cycle; mole one-hot 1 cycle later.
- Press the key matching mole on the 2nd UP cycle -> JUDGE cycle has timeUp=1, W=1; hitCount=1; lives stays 2.
- Press the matching key and a wrong key in the same cycle -> W=0, lives=1.
- Press the matching key exactly on the last UP cycle -> W=1.
- Hold a key from GAP through UP -> W=0.
- Two consecutive misses -> lives 2->1->0, OVER: gameOver=1, enable=0. Pulse start -> lives=2, hitCount=0, new window.
- 200 windows -> mole always one-hot in UP, never equal to the previous hole. Assert reset mid-UP -> IDLE next cycle with no timeUp pulse.
